// File: rtl/ps2_key_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scan-code path: set-2 prefix bytes and
// the parse-state encoding used by the key decoder.
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;  // extended-key prefix
    localparam logic [7:0] SC_BRK = 8'hF0;  // break (release) prefix

    // Bit 0 set means an E0 prefix is pending; bit 1 set means F0 is pending.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } parse_state_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Handshake between the PS/2 receiver FIFO and the key decoder.
//   ready      : FIFO non-empty, data valid
//   data       : scan-code byte at FIFO head
//   overflow   : FIFO lost bytes
//   nextdata_n : active-low one-cycle pop strobe from the decoder
// master = receiver FIFO side, slave = decoder side.
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;

    modport master (output ready, output data, output overflow, input nextdata_n);
    modport slave  (input ready, input data, input overflow, output nextdata_n);
endinterface

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns the set-2 scan-code byte stream into held-key state and one-cycle
// key events (press, typematic repeat, release, error), and counts presses.
// Ports:
//   clk, clr      : clock, asynchronous active-high reset
//   fifo          : receiver FIFO handshake (slave modport)
//   key_code      : scan code of the held key, 0 when none is held
//   key_ext       : held key was E0-prefixed
//   key_valid     : a key is held
//   press_pulse   : new press
//   repeat_pulse  : typematic repeat of the held key
//   release_pulse : held key released
//   err_pulse     : protocol error or overflow flush
//   press_count   : distinct presses since reset, wraps
// All outputs are registered. Event outputs appear in the cycle the pop
// strobe is low, i.e. one cycle after the byte is accepted.
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    ps2_key_decoder_if.slave   fifo,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_valid,
    output logic               press_pulse,
    output logic               repeat_pulse,
    output logic               release_pulse,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   press_count
);

    parse_state_e     state_q;
    logic             nextdata_n_q;
    logic [7:0]       key_code_q;
    logic             key_ext_q;
    logic             key_valid_q;
    logic             press_q, repeat_q, release_q, err_q;
    logic [CNT_W-1:0] count_q;

    logic accept;
    logic hold_match;

    // The strobe is high whenever we are ready for a new byte, so a byte is
    // taken at most once: the cycle after acceptance the strobe is low and
    // the same head byte cannot be accepted again.
    assign accept = fifo.ready && nextdata_n_q;

    // Event extension flag is bit 0 of the state for both make (IDLE/EXT)
    // and break (BRK/EXT_BRK), so one comparator serves both paths.
    assign hold_match = key_valid_q && (fifo.data == key_code_q) &&
                        (state_q[0] == key_ext_q);

    // Pop strobe
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            nextdata_n_q <= 1'b1;
        end else begin
            nextdata_n_q <= !accept;
        end
    end

    // Parse FSM and held-key tracking
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_valid_q <= 1'b0;
            press_q     <= 1'b0;
            repeat_q    <= 1'b0;
            release_q   <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            press_q   <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            err_q     <= 1'b0;
            if (fifo.overflow) begin
                // Framing is unknown after lost bytes: drop everything
                // silently (no release) except the press count. A byte
                // accepted this cycle is still popped but ignored.
                state_q     <= IDLE;
                key_code_q  <= 8'h00;
                key_ext_q   <= 1'b0;
                key_valid_q <= 1'b0;
                err_q       <= 1'b1;
            end else if (accept) begin
                unique case (state_q)
                    IDLE, EXT: begin
                        if (fifo.data == SC_EXT) begin
                            state_q <= EXT;
                        end else if (fifo.data == SC_BRK) begin
                            state_q <= parse_state_e'({1'b1, state_q[0]});
                        end else begin
                            state_q <= IDLE;
                            if (hold_match) begin
                                repeat_q <= 1'b1;
                            end else begin
                                key_code_q  <= fifo.data;
                                key_ext_q   <= state_q[0];
                                key_valid_q <= 1'b1;
                                press_q     <= 1'b1;
                                count_q     <= count_q + 1'b1;
                            end
                        end
                    end
                    BRK, EXT_BRK: begin
                        state_q <= IDLE;
                        if (is_prefix(fifo.data)) begin
                            err_q <= 1'b1;
                        end else if (hold_match) begin
                            release_q   <= 1'b1;
                            key_code_q  <= 8'h00;
                            key_ext_q   <= 1'b0;
                            key_valid_q <= 1'b0;
                        end
                        // Break of a key that is not held is ignored.
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fifo.nextdata_n = nextdata_n_q;
    assign key_code        = key_code_q;
    assign key_ext         = key_ext_q;
    assign key_valid       = key_valid_q;
    assign press_pulse     = press_q;
    assign repeat_pulse    = repeat_q;
    assign release_pulse   = release_q;
    assign err_pulse       = err_q;
    assign press_count     = count_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Consumes the raw scan-code byte stream from the PS/2 receiver FIFO (ready/data/nextdata_n handshake) and turns it into key events. Parses set-2 make/break framing, including the E0 extended prefix and the F0 break prefix. Tracks the currently held key, separates typematic repeats from new presses, and counts distinct presses. Its outputs feed the scan-code-to-ASCII converter and the seven-segment display path downstream.

Parameters:
CNT_W, 8, width of press_count; wraps modulo 2^CNT_W.

Ports:
clk  input  1  system clock
clr  input  1  reset, asynchronous, active-high
ready  input  1  receiver FIFO non-empty; data is valid
data  input  8  scan-code byte at FIFO head
overflow  input  1  receiver FIFO overflowed; bytes were lost
nextdata_n  output  1  active-low pop strobe to receiver, one cycle wide
key_code  output  8  scan code of the held key; 8'h00 when none is held
key_ext  output  1  held key was E0-prefixed
key_valid  output  1  a key is currently held
press_pulse  output  1  one-cycle pulse on a new press
repeat_pulse  output  1  one-cycle pulse on a typematic repeat of the held key
release_pulse  output  1  one-cycle pulse when the held key is released
err_pulse  output  1  one-cycle pulse on a protocol error or overflow flush
press_count  output  CNT_W  number of distinct presses since reset

Behaviour:
- Reset (clr=1, async): nextdata_n=1; key_code=0; key_ext=0; key_valid=0; all pulses=0; press_count=0; FSM=IDLE.
- All outputs are registered.
- Accept condition: a byte is accepted at clock edge N when ready=1 and nextdata_n=1.
- After acceptance: in cycle N+1, nextdata_n=0 (pop occurs at edge N+1), event outputs and pulses are valid, and nextdata_n returns to 1 in N+2.
- Maximum throughput is one byte per 2 cycles. A byte is never consumed twice.
- Parse FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on an accepted byte:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> MAKE(byte, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> MAKE(byte, ext=1) -> IDLE.
  - BRK: E0 or F0 -> err_pulse -> IDLE; any other byte -> BREAK(byte, ext=0) -> IDLE.
  - EXT_BRK: E0 or F0 -> err_pulse -> IDLE; any other byte -> BREAK(byte, ext=1) -> IDLE.
- MAKE(c, e):
  - If key_valid=1 and c==key_code and e==key_ext: repeat_pulse only; count unchanged.
  - Otherwise: key_code=c, key_ext=e, key_valid=1, press_pulse, press_count+1. A new key pressed while another is held replaces the held key.
- BREAK(c, e):
  - If it matches the held key: release_pulse, key_valid=0, key_code=0, key_ext=0.
  - If it does not match: ignored; no pulse; held state unchanged.
- press_count wraps from 2^CNT_W-1 to 0.
- overflow=1 sampled at an edge:
  - FSM -> IDLE; held key cleared (no release_pulse); err_pulse.
  - Any byte accepted in that same cycle is popped but discarded.
  - press_count is preserved.
- At most one of press/repeat/release/err pulses is high in any cycle.
- ready dropping in the cycle nextdata_n is low is legal and needs no special handling.

Decomposition:
- Shared package ps2_pkg holds:
  - constants SC_EXT=8'hE0 and SC_BRK=8'hF0;
  - the 2-bit parse-state encoding IDLE=0, EXT=1, BRK=2, EXT_BRK=3.
- The block is a single module with no sub-module.
- The handshake/pop logic and the parse FSM are separate always blocks.

Test Plan:
- Bytes 1C, F0, 1C with ready gaps -> press_pulse with key_code=1C, key_valid=1, press_count=1; then release_pulse, key_code=00, key_valid=0.
- Typematic stream 1C, 1C, 1C, F0, 1C -> 1 press_pulse, 2 repeat_pulse, 1 release_pulse; press_count=1.
- Extended stream E0, 75, E0, F0, 75 -> press with key_code=75, key_ext=1; release clears key_ext to 0; press_count=1.
- ready held high with 3 queued bytes (1C, 32, 21) -> nextdata_n low exactly 3 times on alternate cycles; key_code ends 21; press_count=3.
- Protocol error F0, F0, then 1C -> err_pulse on the second F0; FSM in IDLE; 1C yields press_pulse.
- Reset mid-frame: E0 accepted, assert clr for 1 cycle, then send 1C -> all outputs zero after reset; 1C is a non-extended press (key_ext=0); press_count=1.
- Overflow: hold key 1C, pulse overflow -> err_pulse, key_valid=0, press_count unchanged; press_count=255 plus one new press -> 0.
